// File: rtl/musb_stage_register.sv
// Parametrised valid/ready pipeline stage with PC/BDS sideband, flush-to-bubble and stall counter.
// Optional skid entry (registered in_ready) enabled by defining MUSB_STAGE_SKID_EN.
module musb_stage_register #(
    parameter int unsigned              DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]    NOP_VALUE  = '0,
    parameter int unsigned              CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [31:0]           in_pc,
    input  logic                  in_is_bds,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [31:0]           out_pc,
    output logic                  out_is_bds,
    output logic                  out_valid,
    output logic                  out_flushed,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  stall_count
);

`ifdef MUSB_STAGE_SKID_EN
    typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;
`else
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
`endif

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] main_data, main_data_nxt;
    logic [31:0]           main_pc, main_pc_nxt;
    logic                  main_bds, main_bds_nxt;
    logic                  flushed, flushed_nxt;
    logic                  in_xfer, out_xfer;

`ifdef MUSB_STAGE_SKID_EN
    logic [DATA_WIDTH-1:0] skid_data, skid_data_nxt;
    logic [31:0]           skid_pc, skid_pc_nxt;
    logic                  skid_bds, skid_bds_nxt;

    assign in_ready = (state != SKID);
`else
    assign in_ready = ~out_valid | out_ready;
`endif

    assign out_valid   = (state != EMPTY);
    assign out_data    = main_data;
    assign out_pc      = main_pc;
    assign out_is_bds  = main_bds;
    assign out_flushed = flushed;
    assign in_xfer     = in_valid & in_ready;
    assign out_xfer    = out_valid & out_ready;

    always_comb begin
        state_nxt     = state;
        main_data_nxt = main_data;
        main_pc_nxt   = main_pc;
        main_bds_nxt  = main_bds;
        flushed_nxt   = flushed;
`ifdef MUSB_STAGE_SKID_EN
        skid_data_nxt = skid_data;
        skid_pc_nxt   = skid_pc;
        skid_bds_nxt  = skid_bds;
`endif
        // Flush drops the incoming entry even though in_ready reported it as accepted.
        if (flush) begin
            state_nxt     = EMPTY;
            main_data_nxt = NOP_VALUE;
            main_pc_nxt   = '0;
            main_bds_nxt  = 1'b0;
            flushed_nxt   = 1'b1;
`ifdef MUSB_STAGE_SKID_EN
            skid_data_nxt = NOP_VALUE;
            skid_pc_nxt   = '0;
            skid_bds_nxt  = 1'b0;
`endif
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state_nxt     = FULL;
                        main_data_nxt = in_data;
                        main_pc_nxt   = in_pc;
                        main_bds_nxt  = in_is_bds;
                        flushed_nxt   = 1'b0;
                    end
                end
                FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_data_nxt = in_data;
                        main_pc_nxt   = in_pc;
                        main_bds_nxt  = in_is_bds;
                        flushed_nxt   = 1'b0;
                    end else if (out_xfer) begin
                        state_nxt     = EMPTY;
                        main_data_nxt = NOP_VALUE;
                        main_pc_nxt   = '0;
                        main_bds_nxt  = 1'b0;
`ifdef MUSB_STAGE_SKID_EN
                    end else if (in_xfer) begin
                        state_nxt     = SKID;
                        skid_data_nxt = in_data;
                        skid_pc_nxt   = in_pc;
                        skid_bds_nxt  = in_is_bds;
`endif
                    end
                end
`ifdef MUSB_STAGE_SKID_EN
                SKID: begin
                    if (out_ready) begin
                        state_nxt     = FULL;
                        main_data_nxt = skid_data;
                        main_pc_nxt   = skid_pc;
                        main_bds_nxt  = skid_bds;
                        skid_data_nxt = NOP_VALUE;
                        skid_pc_nxt   = '0;
                        skid_bds_nxt  = 1'b0;
                    end
                end
`endif
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            main_data <= NOP_VALUE;
            main_pc   <= '0;
            main_bds  <= 1'b0;
            flushed   <= 1'b0;
        end else begin
            state     <= state_nxt;
            main_data <= main_data_nxt;
            main_pc   <= main_pc_nxt;
            main_bds  <= main_bds_nxt;
            flushed   <= flushed_nxt;
        end
    end

`ifdef MUSB_STAGE_SKID_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data <= NOP_VALUE;
            skid_pc   <= '0;
            skid_bds  <= 1'b0;
        end else begin
            skid_data <= skid_data_nxt;
            skid_pc   <= skid_pc_nxt;
            skid_bds  <= skid_bds_nxt;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (out_valid && !out_ready && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_WIDTH'(1);
        end
    end

endmodule
